// File: rtl/fpga_config_loader_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fpga_config_loader_pkg
//  Description : Shared state encoding and width helpers for the fabric
//                configuration loader.
//  Revision    : 1.0 - initial release
// ============================================================================
package fpga_config_loader_pkg;

    // Loader sequencing states, 3-bit encoding shared with fabric-side logic
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_WAIT  = 3'd1,
        ST_SHIFT = 3'd2,
        ST_LATCH = 3'd3,
        ST_DONE  = 3'd4,
        ST_ERROR = 3'd5
    } state_t;

    // Width of the chain bit counter: must hold the value CHAIN_LEN itself
    function automatic int cnt_width(input int chain_len);
        return $clog2(chain_len + 1);
    endfunction

    // Width of the per-word bit counter: must hold the value WORD_W itself
    function automatic int bit_width(input int word_w);
        return $clog2(word_w + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/fpga_config_loader_piso.sv
`default_nettype none
// ============================================================================
//  Module      : fpga_config_loader_piso
//  Description : Word-wide parallel-in / serial-out shifter, LSB first, with
//                a per-word bit counter that flags the last useful bit.
//  Revision    : 1.0 - initial release
// ============================================================================
module fpga_config_loader_piso
    import fpga_config_loader_pkg::*;
#(
    parameter int WORD_W = 8,
    parameter int BIT_W  = bit_width(WORD_W)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_load,
    input  logic [WORD_W-1:0] i_data,
    input  logic [BIT_W-1:0]  i_nbits,
    input  logic              i_shift,
    output logic              o_sdo,
    output logic              o_last
);

    logic [WORD_W-1:0] r_shreg;
    logic [BIT_W-1:0]  r_cnt;
    logic [BIT_W-1:0]  r_nbits;

    // Load a fresh word (restarting the bit count) or shift one bit out
    always_ff @(posedge clk) begin
        if (rst) begin
            r_shreg <= '0;
            r_cnt   <= '0;
            r_nbits <= '0;
        end else if (i_load) begin
            r_shreg <= i_data;
            r_cnt   <= '0;
            r_nbits <= i_nbits;
        end else if (i_shift) begin
            r_shreg <= r_shreg >> 1;
            r_cnt   <= r_cnt + BIT_W'(1);
        end
    end

    assign o_sdo  = r_shreg[0];
    // Only the low nbits of a word reach the chain; the rest are dropped
    assign o_last = ((r_cnt + BIT_W'(1)) == r_nbits);

endmodule
`default_nettype wire

// File: rtl/fpga_config_loader.sv
`default_nettype none
// ============================================================================
//  Module      : fpga_config_loader
//  Description : Accepts a host bitstream, serialises it into the fabric
//                config scan chain, checks its length, commits it with a
//                latch pulse and then releases the fabric pads.
//  Revision    : 1.0 - initial release
// ============================================================================
module fpga_config_loader
    import fpga_config_loader_pkg::*;
#(
    parameter int WORD_W    = 8,
    parameter int CHAIN_LEN = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic              s_valid,
    input  logic [WORD_W-1:0] s_data,
    input  logic              s_last,
    output logic              s_ready,
    output logic              cfg_clk_en,
    output logic              cfg_sdo,
    output logic              cfg_latch,
    output logic              fabric_en,
    output logic              busy,
    output logic              done,
    output logic              error
);

    localparam int c_CNT_W = cnt_width(CHAIN_LEN);
    localparam int c_BIT_W = bit_width(WORD_W);

    state_t               r_state;
    logic [c_CNT_W-1:0]   r_bit_cnt;

    logic [31:0]          w_cnt_ext;
    logic [31:0]          w_remain;
    logic                 w_fin;
    logic                 w_len_bad;
    logic                 w_chain_full;
    logic [c_BIT_W-1:0]   w_nbits;
    logic                 w_accept;
    logic                 w_piso_sdo;
    logic                 w_word_done;

    // Length bookkeeping done in 32 bits so WORD_W may exceed CHAIN_LEN
    assign w_cnt_ext    = 32'(r_bit_cnt);
    assign w_remain     = 32'(CHAIN_LEN) - w_cnt_ext;
    assign w_fin        = (w_cnt_ext + 32'(WORD_W)) >= 32'(CHAIN_LEN);
    assign w_len_bad    = (s_last != w_fin);
    assign w_chain_full = (w_cnt_ext + 32'd1) == 32'(CHAIN_LEN);
    assign w_nbits      = (w_remain >= 32'(WORD_W)) ? c_BIT_W'(WORD_W)
                                                    : c_BIT_W'(w_remain);
    assign w_accept     = (r_state == ST_WAIT) && s_valid;

    fpga_config_loader_piso #(
        .WORD_W (WORD_W),
        .BIT_W  (c_BIT_W)
    ) u_piso (
        .clk     (clk),
        .rst     (rst),
        .i_load  (w_accept),
        .i_data  (s_data),
        .i_nbits (w_nbits),
        .i_shift (r_state == ST_SHIFT),
        .o_sdo   (w_piso_sdo),
        .o_last  (w_word_done)
    );

    // Pass sequencer: abort overrides everything but rst, start only from rest states
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_bit_cnt <= '0;
        end else if (abort) begin
            r_state <= ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_state   <= ST_WAIT;
                        r_bit_cnt <= '0;
                    end
                end
                ST_WAIT: begin
                    // A word failing the length check is never shifted
                    if (s_valid) begin
                        r_state <= w_len_bad ? ST_ERROR : ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    r_bit_cnt <= r_bit_cnt + c_CNT_W'(1);
                    if (w_word_done) begin
                        r_state <= w_chain_full ? ST_LATCH : ST_WAIT;
                    end
                end
                ST_LATCH: begin
                    r_state <= ST_DONE;
                end
                ST_DONE, ST_ERROR: begin
                    if (start) begin
                        r_state   <= ST_WAIT;
                        r_bit_cnt <= '0;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // Every output is a pure decode of registered state
    assign s_ready    = (r_state == ST_WAIT);
    assign cfg_clk_en = (r_state == ST_SHIFT);
    assign cfg_sdo    = (r_state == ST_SHIFT) && w_piso_sdo;
    assign cfg_latch  = (r_state == ST_LATCH);
    assign fabric_en  = (r_state == ST_DONE);
    assign done       = (r_state == ST_DONE);
    assign error      = (r_state == ST_ERROR);
    assign busy       = (r_state == ST_WAIT) || (r_state == ST_SHIFT) ||
                        (r_state == ST_LATCH);

endmodule
`default_nettype wire

// File: tb/tb_fpga_config_loader.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fpga_config_loader
//  Description : Self-checking bench for fpga_config_loader with a stream-level
//                reference model of the serial bitstream and pass outcome.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fpga_config_loader;

    localparam int WW = 8;
    localparam int CL = 20;

    logic clk, rst, start, abort, s_valid, s_last;
    logic [WW-1:0] s_data;
    logic s_ready, cfg_clk_en, cfg_sdo, cfg_latch, fabric_en, busy, done, error;

    logic d2_start, d2_abort, d2_valid, d2_last;
    logic [WW-1:0] d2_data;
    logic d2_ready, d2_clk_en, d2_sdo, d2_latch, d2_fabric_en, d2_busy, d2_done, d2_error;

    wire [7:0] outs    = {s_ready, cfg_clk_en, cfg_sdo, cfg_latch, fabric_en, busy, done, error};
    wire [7:0] d2_outs = {d2_ready, d2_clk_en, d2_sdo, d2_latch, d2_fabric_en, d2_busy, d2_done, d2_error};

    fpga_config_loader #(.WORD_W(WW), .CHAIN_LEN(CL)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .s_valid(s_valid), .s_data(s_data), .s_last(s_last), .s_ready(s_ready),
        .cfg_clk_en(cfg_clk_en), .cfg_sdo(cfg_sdo), .cfg_latch(cfg_latch),
        .fabric_en(fabric_en), .busy(busy), .done(done), .error(error)
    );

    fpga_config_loader #(.WORD_W(WW), .CHAIN_LEN(16)) dut16 (
        .clk(clk), .rst(rst), .start(d2_start), .abort(d2_abort),
        .s_valid(d2_valid), .s_data(d2_data), .s_last(d2_last), .s_ready(d2_ready),
        .cfg_clk_en(d2_clk_en), .cfg_sdo(d2_sdo), .cfg_latch(d2_latch),
        .fabric_en(d2_fabric_en), .busy(d2_busy), .done(d2_done), .error(d2_error)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_fail = 0;
    int n_en = 0;
    int n_lat = 0;
    logic [63:0] cap = '0;
    logic [63:0] m_seq;
    bit exp_q[$];

    logic [WW-1:0] pw_data[8];
    bit pw_last[8];
    int pw_n;
    int m_nacc, m_nen;
    bit m_err;
    int m_off[9];
    int acc_off[8];

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, required %0d", name, act, exp);
        end
    endtask

    // Stream-level reference: walk the words, track chain fill, decide outcome
    function automatic void model();
        int bc, nb;
        bc = 0; m_err = 0; m_nacc = 0; m_nen = 0; m_seq = '0; m_off[0] = 0;
        for (int i = 0; i < pw_n; i++) begin
            m_nacc++;
            if (pw_last[i] != (bc + WW >= CL)) begin
                m_err = 1;
                break;
            end
            nb = (CL - bc < WW) ? (CL - bc) : WW;
            for (int k = 0; k < nb; k++) begin
                exp_q.push_back(pw_data[i][k]);
                m_seq = {m_seq[62:0], pw_data[i][k]};
            end
            bc += nb;
            m_nen += nb;
            m_off[i+1] = m_off[i] + 1 + nb;
            if (pw_last[i]) break;
        end
    endfunction

    // Per-cycle compare of the serial stream and output relations
    task automatic monitor();
        bit eb;
        forever begin
            @(negedge clk);
            if (rst === 1'b0) begin
                n_cmp++;
                if (fabric_en !== done) begin
                    n_fail++;
                    $display("FAIL fabric_en_vs_done: got fabric_en=%b, required %b", fabric_en, done);
                end
                n_cmp++;
                if (cfg_clk_en === 1'b1 && s_ready === 1'b1) begin
                    n_fail++;
                    $display("FAIL ready_in_shift: got s_ready=1 with cfg_clk_en=1, required s_ready=0");
                end
                if (cfg_clk_en === 1'b1) begin
                    n_en++;
                    cap = {cap[62:0], cfg_sdo};
                    n_cmp++;
                    if (exp_q.size() == 0) begin
                        n_fail++;
                        $display("FAIL serial_bit: got unexpected shift sdo=%b, required no shift", cfg_sdo);
                    end else begin
                        eb = exp_q.pop_front();
                        if (cfg_sdo !== eb) begin
                            n_fail++;
                            $display("FAIL serial_bit: got %b, required %b", cfg_sdo, eb);
                        end
                    end
                end
                if (cfg_latch === 1'b1) begin
                    n_lat++;
                    n_cmp++;
                    if (exp_q.size() != 0) begin
                        n_fail++;
                        $display("FAIL latch_early: got %0d bits pending, required 0", exp_q.size());
                    end
                end
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_nominal();
        pw_n = 3;
        pw_data[0] = 8'hA5; pw_last[0] = 0;
        pw_data[1] = 8'h3C; pw_last[1] = 0;
        pw_data[2] = 8'h0F; pw_last[2] = 1;
    endtask

    task automatic run_pass(input bit gaps, input bit poke, input bit chk_off);
        int en0, lat0, t0;
        bit ok;
        model();
        en0 = n_en; lat0 = n_lat;
        start = 1; s_valid = !gaps; s_data = pw_data[0]; s_last = pw_last[0];
        tick();
        start = 0;
        t0 = cyc;
        for (int i = 0; i < m_nacc; i++) begin
            if (gaps) begin
                s_valid = 0;
                repeat ($urandom_range(0, 2)) begin
                    s_last = 1'($urandom_range(0, 1));
                    tick();
                end
            end
            s_valid = 1; s_data = pw_data[i]; s_last = pw_last[i];
            ok = 0;
            for (int w = 0; w < 64; w++) begin
                @(negedge clk);
                if (s_ready === 1'b1) begin
                    ok = 1;
                    acc_off[i] = cyc - t0;
                end else if (poke) begin
                    start = 1;
                end
                tick();
                start = 0;
                if (ok) break;
            end
            if (!ok) begin
                chk("accept_timeout", 0, 1);
                s_valid = 0;
                exp_q.delete();
                return;
            end
        end
        s_valid = 0; s_last = 0;
        if (m_err) begin
            @(negedge clk);
            chk("error_after_bad_accept", int'(error), 1);
        end else begin
            ok = 0;
            for (int w = 0; w < 64; w++) begin
                @(negedge clk);
                if (done === 1'b1) begin
                    ok = 1;
                    break;
                end
            end
            chk("done_reached", int'(ok), 1);
        end
        tick();
        chk("fabric_en_final", int'(fabric_en), int'(!m_err));
        chk("error_final", int'(error), int'(m_err));
        chk("busy_final", int'(busy), 0);
        chk("clk_en_count", n_en - en0, m_nen);
        chk("latch_count", n_lat - lat0, int'(!m_err));
        chk("bits_left", exp_q.size(), 0);
        if (chk_off) begin
            for (int i = 1; i < m_nacc; i++) chk("accept_offset", acc_off[i], m_off[i]);
        end
        exp_q.delete();
    endtask

    initial begin
        int en0, lat0, widx, t0, nb2, lat_off, done_off, lat_cnt;
        bit ok, acc;
        logic [WW-1:0] w0, w1;
        logic [63:0] d2seq, e2seq;

        rst = 1; start = 0; abort = 0; s_valid = 0; s_data = '0; s_last = 0;
        d2_start = 0; d2_abort = 0; d2_valid = 0; d2_data = '0; d2_last = 0;
        fork
            monitor();
        join_none
        repeat (3) tick();
        @(negedge clk);
        chk("reset_outputs", int'(outs), 0);
        chk("reset_outputs_16", int'(d2_outs), 0);
        tick();
        rst = 0;
        tick();

        // Nominal load with valid held high (also the backpressure case)
        set_nominal();
        cap = '0;
        run_pass(0, 0, 1);
        chk("nominal_model_bits", int'(m_seq[19:0]), int'(20'b1010_0101_0011_1100_1111));
        chk("nominal_dut_bits", int'(cap[19:0]), int'(20'b1010_0101_0011_1100_1111));
        chk("nominal_done", int'(done), 1);
        chk("bp_offset1", acc_off[1], 9);
        chk("bp_offset2", acc_off[2], 18);

        // Short stream
        pw_n = 2;
        pw_data[0] = 8'hA5; pw_last[0] = 0;
        pw_data[1] = 8'h3C; pw_last[1] = 1;
        run_pass(0, 0, 1);
        chk("short_model_en", m_nen, 8);
        chk("short_fabric_off", int'(fabric_en), 0);

        // Long stream, then recovery
        set_nominal();
        pw_last[2] = 0;
        run_pass(0, 0, 1);
        chk("long_model_en", m_nen, 16);
        chk("long_error", int'(error), 1);
        set_nominal();
        run_pass(0, 0, 1);
        chk("recover_done", int'(done), 1);

        // Abort on the 4th bit of the second word
        set_nominal();
        model();
        while (exp_q.size() > 12) void'(exp_q.pop_back());
        en0 = n_en; lat0 = n_lat;
        start = 1; s_valid = 1; s_data = 8'hA5; s_last = 0;
        tick();
        start = 0;
        widx = 0; ok = 0;
        for (int w = 0; w < 100; w++) begin
            @(negedge clk);
            acc = (s_ready === 1'b1);
            tick();
            if (acc) begin
                widx++;
                s_data = (widx == 1) ? 8'h3C : 8'h0F;
                s_last = (widx == 2);
            end
            if (n_en - en0 == 11) begin
                ok = 1;
                break;
            end
        end
        chk("abort_reach_bit", int'(ok), 1);
        abort = 1;
        tick();
        abort = 0; s_valid = 0; s_last = 0;
        @(negedge clk);
        chk("abort_outputs", int'(outs), 0);
        repeat (3) tick();
        chk("abort_en_count", n_en - en0, 12);
        chk("abort_no_latch", n_lat - lat0, 0);
        chk("abort_idle_outputs", int'(outs), 0);
        exp_q.delete();
        set_nominal();
        cap = '0;
        run_pass(0, 0, 1);
        chk("after_abort_bits", int'(cap[19:0]), int'(20'b1010_0101_0011_1100_1111));

        // Reset during SHIFT
        set_nominal();
        model();
        en0 = n_en;
        start = 1; s_valid = 1; s_data = 8'hA5; s_last = 0;
        tick();
        start = 0;
        ok = 0;
        for (int w = 0; w < 40; w++) begin
            tick();
            if (n_en - en0 == 3) begin
                ok = 1;
                break;
            end
        end
        chk("rst_reach_bit", int'(ok), 1);
        rst = 1;
        tick();
        rst = 0; s_valid = 0;
        @(negedge clk);
        chk("rst_outputs", int'(outs), 0);
        exp_q.delete();
        tick();

        // start while busy must be ignored
        set_nominal();
        run_pass(0, 1, 1);

        // Randomized passes
        for (int r = 0; r < 24; r++) begin
            bit g;
            int p;
            pw_n = $urandom_range(1, 4);
            p = $urandom_range(0, pw_n - 1);
            for (int j = 0; j < pw_n; j++) begin
                pw_data[j] = WW'($urandom);
                pw_last[j] = (j == p);
            end
            g = 1'($urandom_range(0, 1));
            run_pass(g, (r % 3) == 0, !g);
        end

        // Exact-multiple chain (16 bits, two words)
        w0 = WW'($urandom); w1 = WW'($urandom);
        e2seq = '0;
        for (int k = 0; k < WW; k++) e2seq = {e2seq[62:0], w0[k]};
        for (int k = 0; k < WW; k++) e2seq = {e2seq[62:0], w1[k]};
        d2_start = 1; d2_valid = 1; d2_data = w0; d2_last = 0;
        tick();
        d2_start = 0;
        t0 = cyc;
        d2seq = '0; nb2 = 0; lat_off = -1; done_off = -1; lat_cnt = 0; widx = 0;
        for (int w = 0; w < 40; w++) begin
            @(negedge clk);
            acc = (d2_ready === 1'b1) && (d2_valid === 1'b1);
            if (d2_clk_en === 1'b1) begin
                d2seq = {d2seq[62:0], d2_sdo};
                nb2++;
            end
            if (d2_latch === 1'b1) begin
                lat_cnt++;
                if (lat_off < 0) lat_off = cyc - t0;
            end
            if (d2_done === 1'b1 && done_off < 0) done_off = cyc - t0;
            tick();
            if (acc) begin
                widx++;
                if (widx == 1) begin
                    d2_data = w1; d2_last = 1;
                end else begin
                    d2_valid = 0; d2_last = 0;
                end
            end
        end
        chk("c16_latch_offset", lat_off, 18);
        chk("c16_done_offset", done_off, 19);
        chk("c16_latch_count", lat_cnt, 1);
        chk("c16_shift_count", nb2, 16);
        chk("c16_bits", int'(d2seq[15:0]), int'(e2seq[15:0]));
        chk("c16_fabric_en", int'(d2_fabric_en), 1);

        repeat (2) tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
